// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared types and defaults for the decoder scan sequencer.
package decoder_scan_pkg;

  localparam int SEL_W_DEF = 2;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BLANK  = 2'b01,
    ST_ACTIVE = 2'b10
  } state_e;

endpackage

// File: rtl/decoder_scan_sequencer_next_ch.sv
// Combinational channel finder: next enabled channel above cur, lowest enabled, flags.
module next_ch_find #(
  parameter int SEL_W = 2
) (
  input  logic [(1<<SEL_W)-1:0] mask,
  input  logic [SEL_W-1:0]      cur,
  output logic [SEL_W-1:0]      nxt,
  output logic [SEL_W-1:0]      low,
  output logic                  last,
  output logic                  none
);
  localparam int NCH = 1 << SEL_W;

  // Descending scans so the lowest qualifying index is the one left standing.
  always_comb begin
    nxt  = cur;
    low  = '0;
    last = 1'b1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) low = SEL_W'(i);
      if (mask[i] && (i > int'(cur))) begin
        nxt  = SEL_W'(i);
        last = 1'b0;
      end
    end
    none = ~|mask;
  end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Walks a decoder select through enabled channels with break-before-make blanking.
module decoder_scan_sequencer
  import decoder_scan_pkg::*;
#(
  parameter int SEL_W     = SEL_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int BLANK_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  continuous,
  input  logic [CNT_W-1:0]      dwell,
  input  logic [(1<<SEL_W)-1:0] ch_mask,
  output logic [SEL_W-1:0]      sel_out,
  output logic                  en_out,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int NCH = 1 << SEL_W;
  localparam int BW  = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam logic [BW-1:0] BLANK_LAST = (BLANK_CYC > 0) ? BW'(BLANK_CYC - 1) : '0;

  state_e              state, state_nx;
  logic [SEL_W-1:0]    sel_nx;
  logic                en_nx, busy_nx, fd_nx;
  logic [CNT_W-1:0]    dwell_lat, dwell_lat_nx, dwell_cnt, dwell_cnt_nx;
  logic [NCH-1:0]      mask_lat, mask_lat_nx;
  logic                cont_lat, cont_lat_nx;
  logic [BW-1:0]       blank_cnt, blank_cnt_nx;

  logic [NCH-1:0]      f_mask;
  logic [SEL_W-1:0]    f_nxt, f_low, wrap_low;
  logic                f_last, f_none;

  // In IDLE the finder looks at the live mask to pick the first channel;
  // mid-frame it walks the latched one.
  assign f_mask = (state == ST_IDLE) ? ch_mask : mask_lat;

  next_ch_find #(.SEL_W(SEL_W)) u_find (
    .mask (f_mask),
    .cur  (sel_out),
    .nxt  (f_nxt),
    .low  (f_low),
    .last (f_last),
    .none (f_none)
  );

  // Wrap target comes from the live mask, which is re-latched at the same edge.
  always_comb begin
    wrap_low = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (ch_mask[i]) wrap_low = SEL_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel_out    <= '0;
      en_out     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      dwell_lat  <= '0;
      dwell_cnt  <= '0;
      mask_lat   <= '0;
      cont_lat   <= 1'b0;
      blank_cnt  <= '0;
    end else begin
      state      <= state_nx;
      sel_out    <= sel_nx;
      en_out     <= en_nx;
      busy       <= busy_nx;
      frame_done <= fd_nx;
      dwell_lat  <= dwell_lat_nx;
      dwell_cnt  <= dwell_cnt_nx;
      mask_lat   <= mask_lat_nx;
      cont_lat   <= cont_lat_nx;
      blank_cnt  <= blank_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    sel_nx       = sel_out;
    en_nx        = en_out;
    busy_nx      = busy;
    fd_nx        = 1'b0;
    dwell_lat_nx = dwell_lat;
    dwell_cnt_nx = dwell_cnt;
    mask_lat_nx  = mask_lat;
    cont_lat_nx  = cont_lat;
    blank_cnt_nx = blank_cnt;

    unique case (state)
      ST_IDLE: begin
        if (start && !stop && !f_none) begin
          dwell_lat_nx = (dwell == '0) ? CNT_W'(1) : dwell;
          mask_lat_nx  = ch_mask;
          cont_lat_nx  = continuous;
          sel_nx       = f_low;
          state_nx     = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (stop) state_nx = ST_IDLE;
        else if (blank_cnt == BLANK_LAST) begin
          state_nx     = ST_ACTIVE;
          en_nx        = 1'b1;
          dwell_cnt_nx = '0;
        end else blank_cnt_nx = blank_cnt + 1'b1;
      end
      ST_ACTIVE: begin
        if (stop) state_nx = ST_IDLE;
        else if (dwell_cnt == dwell_lat - 1'b1) begin
          if (!f_last) begin
            sel_nx   = f_nxt;
            state_nx = ST_BLANK;
          end else begin
            fd_nx = 1'b1;
            if (cont_lat && ch_mask != '0) begin
              dwell_lat_nx = (dwell == '0) ? CNT_W'(1) : dwell;
              mask_lat_nx  = ch_mask;
              cont_lat_nx  = continuous;
              sel_nx       = wrap_low;
              state_nx     = ST_BLANK;
            end else state_nx = ST_IDLE;
          end
        end else dwell_cnt_nx = dwell_cnt + 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase

    // Common entry actions; a zero-blank build skips BLANK entirely.
    if (state_nx == ST_IDLE) begin
      en_nx   = 1'b0;
      busy_nx = 1'b0;
    end else if (state_nx == ST_BLANK && state_nx != state || (state == ST_ACTIVE && state_nx == ST_BLANK)) begin
      busy_nx      = 1'b1;
      blank_cnt_nx = '0;
      if (BLANK_CYC == 0) begin
        state_nx     = ST_ACTIVE;
        en_nx        = 1'b1;
        dwell_cnt_nx = '0;
      end else en_nx = 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer (BLANK_CYC=2 main DUT, BLANK_CYC=0 companion).
module tb_decoder_scan_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic [3:0] ch_mask = 4'd0;
  logic [1:0] sel, sel0;
  logic       en, busy, fd, en0, busy0, fd0;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  decoder_scan_sequencer #(.SEL_W(2), .CNT_W(8), .BLANK_CYC(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
    .dwell(dwell), .ch_mask(ch_mask), .sel_out(sel), .en_out(en), .busy(busy),
    .frame_done(fd));

  decoder_scan_sequencer #(.SEL_W(2), .CNT_W(8), .BLANK_CYC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
    .dwell(dwell), .ch_mask(ch_mask), .sel_out(sel0), .en_out(en0), .busy(busy0),
    .frame_done(fd0));

  // Observation word: {sel, en, busy, frame_done}
  function automatic logic [4:0] pk(input logic [1:0] s, input logic e, b, f);
    return {s, e, b, f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic abort();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset", pk(sel, en, busy, fd), pk(2'd0, 1'b0, 1'b0, 1'b0));
    chk("reset0", pk(sel0, en0, busy0, fd0), 5'd0);
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    chk("idle_after_reset", pk(sel, en, busy, fd), 5'd0);

    // 1: full mask, dwell 3, one-shot
    ch_mask = 4'hF; dwell = 8'd3; continuous = 1'b0;
    pulse_start();
    for (int ch = 0; ch < 4; ch++)
      for (int p = 0; p < 5; p++) begin
        chk($sformatf("t1_ch%0d_p%0d", ch, p), pk(sel, en, busy, fd),
            pk(2'(ch), (p >= 2), 1'b1, 1'b0));
        tick();
      end
    chk("t1_frame_done", pk(sel, en, busy, fd), pk(2'd3, 1'b0, 1'b0, 1'b1));
    tick();
    chk("t1_fd_pulse_end", pk(sel, en, busy, fd), pk(2'd3, 1'b0, 1'b0, 1'b0));

    // 2: sparse mask, dwell 1, continuous
    ch_mask = 4'b1010; dwell = 8'd1; continuous = 1'b1;
    pulse_start();
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 2; c++)
        for (int p = 0; p < 3; p++) begin
          chk($sformatf("t2_f%0d_c%0d_p%0d", f, c, p), pk(sel, en, busy, fd),
              pk((c == 0) ? 2'd1 : 2'd3, (p == 2), 1'b1, (f > 0 && c == 0 && p == 0)));
          tick();
        end
    chk("t2_wrap_fd", pk(sel, en, busy, fd), pk(2'd1, 1'b0, 1'b1, 1'b1));
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t2_stop", pk(sel, en, busy, fd), pk(2'd1, 1'b0, 1'b0, 1'b0));
    tick();

    // 3: dwell 0 behaves as 1; zero-blank build runs back to back
    ch_mask = 4'b0110; dwell = 8'd0; continuous = 1'b0;
    abort();
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_main_%0d", i), pk(sel, en, busy, fd),
          pk((i < 3) ? 2'd1 : 2'd2, (i % 3 == 2), 1'b1, 1'b0));
      chk($sformatf("t3_nob_%0d", i), pk(sel0, en0, busy0, fd0),
          (i == 0) ? pk(2'd1, 1'b1, 1'b1, 1'b0) :
          (i == 1) ? pk(2'd2, 1'b1, 1'b1, 1'b0) :
          (i == 2) ? pk(2'd2, 1'b0, 1'b0, 1'b1) : pk(2'd2, 1'b0, 1'b0, 1'b0));
      tick();
    end
    chk("t3_main_fd", pk(sel, en, busy, fd), pk(2'd2, 1'b0, 1'b0, 1'b1));
    tick();

    // 4: stop during ch2 ACTIVE, then restart at ch0
    ch_mask = 4'hF; dwell = 8'd3;
    abort();
    pulse_start();
    repeat (12) tick();
    chk("t4_on_ch2", pk(sel, en, busy, fd), pk(2'd2, 1'b1, 1'b1, 1'b0));
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t4_stopped", pk(sel, en, busy, fd), pk(2'd2, 1'b0, 1'b0, 1'b0));
    tick();
    chk("t4_no_fd", pk(sel, en, busy, fd), pk(2'd2, 1'b0, 1'b0, 1'b0));
    pulse_start();
    chk("t4_restart", pk(sel, en, busy, fd), pk(2'd0, 1'b0, 1'b1, 1'b0));
    abort();

    // 5: empty mask ignored; start while busy ignored
    ch_mask = 4'h0;
    pulse_start();
    chk("t5_mask0", pk(sel, en, busy, fd), pk(2'd0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("t5_mask0_hold", pk(sel, en, busy, fd), pk(2'd0, 1'b0, 1'b0, 1'b0));
    ch_mask = 4'hF; dwell = 8'd1;
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t5_busy_%0d", i), pk(sel, en, busy, fd),
          pk(2'(i / 3), (i % 3 == 2), 1'b1, 1'b0));
      start = (i % 2 == 0);
      tick();
    end
    start = 1'b0;
    chk("t5_fd", pk(sel, en, busy, fd), pk(2'd3, 1'b0, 1'b0, 1'b1));
    tick();

    // 6: async reset mid-ACTIVE
    dwell = 8'd3;
    pulse_start();
    tick(); tick();
    chk("t6_active", pk(sel, en, busy, fd), pk(2'd0, 1'b1, 1'b1, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async", pk(sel, en, busy, fd), 5'd0);
    #2 rst_n = 1'b1;
    tick(); tick(); tick();
    chk("t6_stay_idle", pk(sel, en, busy, fd), 5'd0);
    pulse_start();
    chk("t6_restart", pk(sel, en, busy, fd), pk(2'd0, 1'b0, 1'b1, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
